// File: rtl/nanorv32_mem_dma.sv
// Word-copy / word-fill DMA initiator for the nanorv32 native memory interface.
// Every transaction is followed by one idle bus cycle; stalled requests abort after TIMEOUT_CYCLES.
module nanorv32_mem_dma #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             fill,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_GAP} state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [LEN_W-1:0] words_done_q, words_done_d;
  logic             mem_valid_q, mem_valid_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             fill_q, fill_d;
  logic [31:0]      fdata_q, fdata_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             next_wr_q, next_wr_d;
  logic             zero_q, zero_d;

  // State and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      words_done_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      mem_wstrb_q  <= 4'b0000;
      src_q        <= 32'h0000_0000;
      dst_q        <= 32'h0000_0000;
      len_q        <= '0;
      fill_q       <= 1'b0;
      fdata_q      <= 32'h0000_0000;
      tcnt_q       <= '0;
      next_wr_q    <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      words_done_q <= words_done_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      fill_q       <= fill_d;
      fdata_q      <= fdata_d;
      tcnt_q       <= tcnt_d;
      next_wr_q    <= next_wr_d;
      zero_q       <= zero_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    words_done_d = words_done_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    fill_d       = fill_q;
    fdata_d      = fdata_q;
    tcnt_d       = tcnt_q;
    next_wr_d    = next_wr_q;
    zero_d       = zero_q;

    case (state_q)
      S_IDLE: begin
        // zero_q marks an accepted zero-length request: one busy cycle, then done.
        if (zero_q) begin
          zero_d = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (start) begin
          fill_d       = fill;
          len_d        = len;
          fdata_d      = fill_data;
          src_d        = {src_addr[31:2], 2'b00};
          dst_d        = {dst_addr[31:2], 2'b00};
          error_d      = 1'b0;
          words_done_d = '0;
          busy_d       = 1'b1;
          tcnt_d       = '0;
          if (len == '0) begin
            zero_d = 1'b1;
          end else if (fill) begin
            state_d     = S_WRITE;
            mem_valid_d = 1'b1;
            mem_addr_d  = {dst_addr[31:2], 2'b00};
            mem_wstrb_d = 4'b1111;
            mem_wdata_d = fill_data;
          end else begin
            state_d     = S_READ;
            mem_valid_d = 1'b1;
            mem_addr_d  = {src_addr[31:2], 2'b00};
            mem_wstrb_d = 4'b0000;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_READ: begin
        if (mem_ready) begin
          mem_wdata_d = mem_rdata;
          src_d       = src_q + 32'd4;
          mem_valid_d = 1'b0;
          next_wr_d   = 1'b1;
          state_d     = S_GAP;
        end else if (tcnt_q == TLIM) begin
          mem_valid_d = 1'b0;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          error_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          dst_d        = dst_q + 32'd4;
          words_done_d = words_done_q + LEN_W'(1);
          mem_valid_d  = 1'b0;
          if (words_done_q + LEN_W'(1) == len_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = S_GAP;
            next_wr_d = fill_q;
          end
        end else if (tcnt_q == TLIM) begin
          mem_valid_d = 1'b0;
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          error_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_GAP: begin
        mem_valid_d = 1'b1;
        tcnt_d      = '0;
        if (next_wr_q) begin
          state_d     = S_WRITE;
          mem_addr_d  = dst_q;
          mem_wstrb_d = 4'b1111;
          // In copy mode mem_wdata already holds the captured read word.
          if (fill_q) begin
            mem_wdata_d = fdata_q;
          end else begin
            mem_wdata_d = mem_wdata_q;
          end
        end else begin
          state_d     = S_READ;
          mem_addr_d  = src_q;
          mem_wstrb_d = 4'b0000;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = words_done_q;
  assign mem_valid  = mem_valid_q;
  assign mem_instr  = 1'b0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_nanorv32_mem_dma.sv
// Scoreboard bench for nanorv32_mem_dma: a reference model queues expected bus transactions,
// a negedge monitor pops and compares them at every completed transaction.
module tb_nanorv32_mem_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len = 16'h0;
  logic [31:0] fill_data = 32'h0;
  logic        busy, done, error, mem_valid, mem_instr;
  logic [15:0] words_done;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  nanorv32_mem_dma #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .fill(fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_data(fill_data),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  bit   [31:0] mem[1024];
  bit   [31:0] ref_mem[1024];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          block_en = 1'b0;
  logic [31:0] block_addr = 32'h0;
  bit          bd_we = 1'b0;
  logic [9:0]  bd_idx = 10'd0;
  logic [31:0] bd_data = 32'h0;
  int          rcnt = 0;
  int          txn_count = 0;
  bit          any_valid = 1'b0;
  bit          gap_pending = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responder: ready `lat` cycles after seeing mem_valid, optionally never for a blocked read.
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (reset) begin
      mem_ready <= 1'b0;
      rcnt      <= 0;
    end else if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'hF) mem[mem_addr[11:2]] <= mem_wdata;
      mem_ready <= 1'b0;
      rcnt      <= 0;
    end else if (mem_valid && !(block_en && mem_wstrb == 4'h0 && mem_addr == block_addr)) begin
      if (rcnt + 1 >= lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem[mem_addr[11:2]];
      end else begin
        rcnt <= rcnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      rcnt      <= 0;
    end
  end

  // Monitor: compare each completed transaction, the idle cycle after it, and stalled-bus stability.
  always @(negedge clk) begin
    if (reset) begin
      gap_pending = 1'b0;
      prev_stall  = 1'b0;
    end else begin
      if (mem_valid) any_valid = 1'b1;
      if (gap_pending) begin
        gap_pending = 1'b0;
        chk("gap_after_txn", {63'd0, mem_valid}, 64'd0);
      end
      if (prev_stall && mem_valid) begin
        chk("stable_addr", {32'd0, mem_addr}, {32'd0, prev_addr});
        chk("stable_wstrb", {60'd0, mem_wstrb}, {60'd0, prev_wstrb});
        if (mem_wstrb == 4'hF) chk("stable_wdata", {32'd0, mem_wdata}, {32'd0, prev_wdata});
      end
      if (mem_valid && mem_ready) begin
        txn_count++;
        gap_pending = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_txn_addr", {32'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          txn_t e;
          e = exp_q.pop_front();
          chk("txn_addr", {32'd0, mem_addr}, {32'd0, e.addr});
          chk("txn_wstrb", {60'd0, mem_wstrb}, {60'd0, (e.we ? 4'hF : 4'h0)});
          if (e.we) chk("txn_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_wstrb = mem_wstrb;
    end
  end

  // Reference model: sequential word-by-word copy/fill on ref_mem, queueing the expected bus traffic.
  task automatic model_push(input bit f, input logic [31:0] s, input logic [31:0] d,
                            input int n, input logic [31:0] fd);
    logic [31:0] sp, dp, v;
    sp = s & 32'hFFFF_FFFC;
    dp = d & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      if (f) begin
        v = fd;
      end else begin
        v = ref_mem[sp[11:2]];
        exp_q.push_back('{addr: sp, we: 1'b0, data: 32'h0});
        sp = sp + 32'd4;
      end
      exp_q.push_back('{addr: dp, we: 1'b1, data: v});
      ref_mem[dp[11:2]] = v;
      dp = dp + 32'd4;
    end
  endtask

  task automatic run_xfer(input string tag, input bit f, input logic [31:0] s, input logic [31:0] d,
                          input int n, input logic [31:0] fd, input int exp_edge,
                          input int exp_words, input bit exp_err, input bit ign);
    int t0, k;
    logic [31:0] dp;
    @(negedge clk);
    fill = f; src_addr = s; dst_addr = d; len = 16'(n); fill_data = fd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    chk({tag, "_busy_after_start"}, {63'd0, busy}, 64'd1);
    chk({tag, "_error_cleared"}, {63'd0, error}, 64'd0);
    k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
      if (ign && k == 3) begin
        start = 1'b1; fill = ~f; dst_addr = 32'h0000_0700; src_addr = 32'h0000_0040;
        len = 16'd7; fill_data = 32'h5555_AAAA;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      chk({tag, "_done_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (exp_edge >= 0) chk({tag, "_done_edge"}, 64'(cyc - t0), 64'(exp_edge));
    chk({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({tag, "_words_done"}, {48'd0, words_done}, 64'(exp_words));
    chk({tag, "_error"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, "_valid_at_done"}, {63'd0, mem_valid}, 64'd0);
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    dp = d & 32'hFFFF_FFFC;
    for (int i = 0; i < exp_words; i++) begin
      chk({tag, "_mem"}, {32'd0, mem[dp[11:2]]}, {32'd0, ref_mem[dp[11:2]]});
      dp = dp + 32'd4;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc;
    logic [31:0] r;
    reset = 1'b1;
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, mem_valid}, 64'd0);
    chk("reset_addr", {32'd0, mem_addr}, 64'd0);
    chk("reset_words_done", {48'd0, words_done}, 64'd0);
    chk("mem_instr_zero", {63'd0, mem_instr}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Preload bench memory and the model's copy through the responder's backdoor port.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      r = $urandom;
      if (i >= 64 && i <= 67) r = 32'(i - 63);
      bd_we = 1'b1; bd_idx = 10'(i); bd_data = r;
      ref_mem[i] = r;
    end
    @(negedge clk);
    bd_we = 1'b0;

    // Copy 0x100..0x10C -> 0x200.
    lat = 1;
    tc = txn_count;
    model_push(1'b0, 32'h100, 32'h200, 4, 32'h0);
    run_xfer("copy", 1'b0, 32'h100, 32'h200, 4, 32'h0, 23, 4, 1'b0, 1'b0);
    chk("copy_txn_count", 64'(txn_count - tc), 64'd8);
    chk("copy_word0", {32'd0, mem[128]}, 64'd1);
    chk("copy_word3", {32'd0, mem[131]}, 64'd4);

    // Fill with unaligned destination.
    model_push(1'b1, 32'h0, 32'h403, 3, 32'hDEAD_BEEF);
    run_xfer("fill", 1'b1, 32'h0, 32'h403, 3, 32'hDEAD_BEEF, 8, 3, 1'b0, 1'b0);

    // Zero length.
    any_valid = 1'b0;
    run_xfer("zero", 1'b0, 32'h100, 32'h200, 0, 32'h0, 1, 0, 1'b0, 1'b0);
    chk("zero_no_valid", {63'd0, any_valid}, 64'd0);

    // Timeout on a read of 0x300.
    block_en = 1'b1; block_addr = 32'h300;
    run_xfer("timeout", 1'b0, 32'h300, 32'h500, 2, 32'h0, 8, 0, 1'b1, 1'b0);
    block_en = 1'b0;
    model_push(1'b1, 32'h0, 32'h520, 1, 32'h1234_5678);
    run_xfer("after_timeout", 1'b1, 32'h0, 32'h520, 1, 32'h1234_5678, 2, 1, 1'b0, 1'b0);

    // Ignored start while busy.
    model_push(1'b0, 32'h100, 32'h600, 3, 32'h0);
    run_xfer("ignored_start", 1'b0, 32'h100, 32'h600, 3, 32'h0, 17, 3, 1'b0, 1'b1);

    // Address wrap.
    model_push(1'b1, 32'h0, 32'hFFFF_FFFC, 2, 32'hCAFE_F00D);
    run_xfer("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 2, 32'hCAFE_F00D, 5, 2, 1'b0, 1'b0);

    // Randomized copies and fills with variable responder latency.
    for (int it = 0; it < 24; it++) begin
      bit f;
      logic [31:0] s, d, fd;
      int n;
      f   = 1'($urandom_range(0, 1));
      s   = 32'($urandom_range(0, 1000)) << 2;
      d   = (32'($urandom_range(0, 1000)) << 2) | 32'($urandom_range(0, 3));
      n   = $urandom_range(1, 6);
      fd  = $urandom;
      lat = $urandom_range(1, 3);
      model_push(f, s, d, n, fd);
      run_xfer("random", f, s, d, n, fd, (lat == 1) ? (f ? 3 * n - 1 : 6 * n - 1) : -1, n, 1'b0, 1'b0);
    end

    // Reset while a write is outstanding.
    lat = 3;
    model_push(1'b1, 32'h0, 32'h800, 4, 32'hA5A5_5A5A);
    @(negedge clk);
    fill = 1'b1; dst_addr = 32'h800; len = 16'd4; fill_data = 32'hA5A5_5A5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tc = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && !mem_ready) && tc < 100) begin
      @(negedge clk);
      tc++;
    end
    chk("rst_reached_write", {63'd0, mem_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    chk("rst_async_done", {63'd0, done}, 64'd0);
    chk("rst_async_error", {63'd0, error}, 64'd0);
    chk("rst_async_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst_async_wstrb", {60'd0, mem_wstrb}, 64'd0);
    chk("rst_async_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_async_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_async_words", {48'd0, words_done}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    any_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_no_bus_activity", {63'd0, any_valid}, 64'd0);
    chk("rst_idle_busy", {63'd0, busy}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nanorv32_mem_dma.md
Name: nanorv32_mem_dma

Overview:
- Word-copy / word-fill DMA engine acting as **initiator** on the nanorv32 native memory interface (mem_valid / mem_ready / mem_addr / mem_wdata / mem_wstrb / mem_rdata).
- Issues word reads and writes to any responder: the bench memory model, peripherals, or the memory side of an arbiter.
- Used in benches to preload or scrub memory. Also the template for a future SoC DMA.

Parameters:
- LEN_W, 16, width of the length and progress counters, in words.
- TIMEOUT_CYCLES, 1024, maximum cycles mem_valid may stay high without mem_ready before the transfer aborts. Must be ≥ 2.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- fill  in  1  sampled with start: 1 = write fill_data to every word, 0 = copy src→dst
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len  in  LEN_W  transfer length in 32-bit words
- fill_data  in  32  pattern word for fill mode; sampled with start
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse when a transfer ends, normally or by abort
- error  out  1  sticky timeout flag; cleared by an accepted start
- words_done  out  LEN_W  number of completed writes in the current or last transfer
- mem_valid  out  1  transaction request
- mem_instr  out  1  tied 0
- mem_ready  in  1  responder completion; a transaction completes at a clock edge where mem_valid && mem_ready
- mem_addr  out  32  word-aligned byte address (bits [1:0] always 0)
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads
- mem_rdata  in  32  read data; valid only at the completion edge of a read

Behaviour:
- **Reset** (asynchronous, immediate), all outputs 0:
  - state = IDLE; busy, done, error, mem_valid, mem_wstrb = 0
  - mem_addr, mem_wdata, words_done = 0
  - internal address pointers and counters = 0
- All outputs are registered.
- **States:** IDLE, READ, WRITE, GAP.
- **IDLE:**
  - On start, latch fill, len, fill_data, {src_addr[31:2],2'b00}, {dst_addr[31:2],2'b00}.
  - Clear error and words_done; set busy.
  - len = 0: go nowhere. done pulses the next cycle, busy returns to 0 in the same edge, no bus traffic.
  - Otherwise go to READ (copy) or WRITE (fill). mem_valid rises at the same edge.
- **READ:**
  - Drive mem_addr = src pointer, mem_wstrb = 0.
  - On completion: capture mem_rdata into mem_wdata, src += 4, mem_valid = 0, go to GAP (next = WRITE).
- **WRITE:**
  - Drive mem_addr = dst pointer, mem_wstrb = 4'b1111, mem_wdata = captured data (copy) or fill_data (fill).
  - On completion: dst += 4, words_done += 1, mem_valid = 0.
  - If words_done + 1 == len: go to IDLE, busy = 0, done = 1 for one cycle.
  - Else go to GAP (next = READ for copy, WRITE for fill).
- **GAP:** exactly one cycle with mem_valid = 0, then enter the next state with mem_valid = 1.
  - mem_valid is never high on two consecutive transactions without a low cycle between them.
- **Bus stability:** mem_addr, mem_wdata and mem_wstrb are constant while mem_valid = 1 and mem_ready = 0.
- **Pointer wrap:** pointers wrap modulo 2^32; no fault on wrap.
- **Timing** with a responder asserting mem_ready one cycle after it sees mem_valid:
  - copy takes 6 cycles per word; done is high in the cycle after edge 6N-1 counted from the start edge (start edge = 0)
  - fill takes 3 cycles per word; done edge is 3N-1
- **Timeout:**
  - The counter clears at every rising of mem_valid and increments each cycle mem_valid && !mem_ready.
  - On reaching TIMEOUT_CYCLES: mem_valid = 0, go to IDLE, busy = 0, done pulse, error = 1.
  - words_done holds the completed-write count.
  - A late mem_ready after an abort is ignored.
- **start handling:**
  - start while busy is ignored. It has no effect on latched values.
  - start in the same cycle that done is asserted is accepted, because the state is already IDLE.
- **Ordering:** a read's data is never written before that read completes; words are processed in ascending address order.

Test Plan:
1. **Copy:** memory words 0x100..0x10C = 1,2,3,4; copy, src=0x100, dst=0x200, len=4, 1-cycle responder.
   - Required: 0x200..0x20C = 1,2,3,4.
   - done at edge 23; words_done = 4; 8 transactions observed; mem_valid low between each.
2. **Fill:** fill=1, fill_data=0xDEADBEEF, dst=0x403 (unaligned), len=3.
   - Required: writes to 0x400, 0x404, 0x408 with wstrb 1111; no reads; done at edge 8.
3. **Zero length:** len=0.
   - Required: no mem_valid; done pulse in the cycle after start; busy high for exactly one cycle.
4. **Timeout:** TIMEOUT_CYCLES=8; responder never asserts mem_ready on reads of 0x300.
   - Required: mem_valid drops after 8 stalled cycles; error = 1, done pulse, words_done = 0.
   - A subsequent successful start clears error.
5. **Reset mid-transfer:** assert reset while in WRITE with mem_valid = 1.
   - Required: all outputs 0 asynchronously, before the next edge.
   - After release: IDLE, no bus activity until start.
6. **Ignored start and wrap:** pulse start again while busy; separately run fill at dst=0xFFFFFFFC, len=2.
   - Required: the second start has no effect.
   - The fill writes 0xFFFFFFFC then 0x00000000.
